// File: rtl/log_afpm_pkg.sv
// Shared definitions for the log-domain approximate floating-point multiplier.
// Contents:
//   state_t    - control FSM states (COLLECT, CALC1, CALC2, SEND)
//   FLAG_OVF   - bit index of the overflow/saturation flag in flags
//   FLAG_UNF   - bit index of the underflow flag in flags
//   bias()     - exponent bias for a given exponent field width
package log_afpm_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC1   = 2'd1,
    CALC2   = 2'd2,
    SEND    = 2'd3
  } state_t;

  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/log_afpm_datapath.sv
// Two-stage Mitchell (log-domain) multiplier arithmetic.
// Stage CALC1 (calc1_en) registers sign, mantissa sum and biased exponent sum;
// stage CALC2 (calc2_en) normalises, applies the special cases and registers
// the result word and flags.
// Optional feature: LOG_AFPM_CORR_EN adds min(ma,mb)>>2 to the mantissa sum
// (clamped) as a first-order correction of the Mitchell error.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   calc1_en  - perform the first stage this cycle
//   calc2_en  - perform the second stage this cycle
//   a, b      - operand words {sign, exponent, mantissa}
//   result    - registered result word
//   flags     - registered {ovf, unf}
module log_afpm_datapath
  import log_afpm_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     calc1_en,
  input  logic                     calc2_en,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [1:0]               flags
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int BIAS    = bias(EXP_W);
  localparam int MAX_EXP = (1 << EXP_W) - 2;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];

  // ---------------- stage 1 ----------------
  logic                    sign_reg;
  logic [MAN_W:0]          s_reg, s_next;
  logic signed [EXP_W+1:0] e_reg, e_next;
  logic                    zero_reg, inf_reg;
  int                      e_sum;

`ifdef LOG_AFPM_CORR_EN
  logic [MAN_W-1:0] m_min;
  logic [MAN_W+1:0] s_wide;
  always_comb begin
    m_min  = (ma < mb) ? ma : mb;
    s_wide = {2'b00, ma} + {2'b00, mb} + {2'b00, (m_min >> 2)};
    // Clamp to the MAN_W+1 bit range so normalisation still sees a value
    // below 2^(MAN_W+1).
    s_next = s_wide[MAN_W+1] ? {(MAN_W+1){1'b1}} : s_wide[MAN_W:0];
  end
`else
  assign s_next = {1'b0, ma} + {1'b0, mb};
`endif

  always_comb begin
    e_sum  = int'(ea) + int'(eb) - BIAS;
    e_next = (EXP_W+2)'(e_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_reg <= 1'b0;
      s_reg    <= '0;
      e_reg    <= '0;
      zero_reg <= 1'b0;
      inf_reg  <= 1'b0;
    end else if (calc1_en) begin
      sign_reg <= a[W-1] ^ b[W-1];
      s_reg    <= s_next;
      e_reg    <= e_next;
      zero_reg <= (ea == '0) || (eb == '0);
      inf_reg  <= (ea == '1) || (eb == '1);
    end
  end

  // ---------------- stage 2 ----------------
  logic [W-1:0] result_next;
  logic [1:0]   flags_next;
  int           exp_i;

  always_comb begin
    result_next = '0;
    flags_next  = 2'b00;
    exp_i       = int'(e_reg);
    // Mantissa sum carried into the hidden-bit position: bump exponent, the
    // low MAN_W bits are then exactly s - 2^MAN_W.
    if (s_reg[MAN_W]) exp_i = exp_i + 1;
    result_next = {sign_reg, exp_i[EXP_W-1:0], s_reg[MAN_W-1:0]};
    if (zero_reg) begin
      result_next = {sign_reg, {(W-1){1'b0}}};
    end else if (inf_reg || (exp_i > MAX_EXP)) begin
      result_next = {sign_reg, EXP_W'(MAX_EXP), {MAN_W{1'b1}}};
      flags_next[FLAG_OVF] = 1'b1;
    end else if (exp_i < 1) begin
      result_next = {sign_reg, {(W-1){1'b0}}};
      flags_next[FLAG_UNF] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flags  <= 2'b00;
    end else if (calc2_en) begin
      result <= result_next;
      flags  <= flags_next;
    end
  end

endmodule

// File: rtl/log_afpm_param.sv
// Beat-serial log-domain approximate floating-point multiplier (top).
// Operands arrive as NB = ceil(W/BUS_W) beats, least significant first; the
// product leaves the same way. Arithmetic is in log_afpm_datapath.
// Optional feature: LOG_AFPM_CORR_EN (mantissa correction, see datapath).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand beat handshake (ready only in COLLECT)
//   a_in, b_in          - operand beats
//   out_valid/out_ready - result beat handshake (valid only in SEND)
//   out_data            - result beat
//   flags               - {ovf, unf}, valid while out_valid
module log_afpm_param
  import log_afpm_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] a_in,
  input  logic [BUS_W-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic [1:0]       flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int NB    = (W + BUS_W - 1) / BUS_W;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] beat_reg, beat_next;
  logic             calc1_en, calc2_en;

  logic [NB*BUS_W-1:0] a_reg, b_reg, res_wide;
  logic [W-1:0]        result;
  logic [1:0]          flags_dp;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= COLLECT;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    calc1_en   = 1'b0;
    calc2_en   = 1'b0;
    case (state_reg)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (beat_reg == LAST) begin
            beat_next  = '0;
            state_next = CALC1;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      CALC1: begin
        calc1_en   = 1'b1;
        state_next = CALC2;
      end
      CALC2: begin
        calc2_en   = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (beat_reg == LAST) begin
            beat_next  = '0;
            state_next = COLLECT;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = COLLECT;
        beat_next  = '0;
      end
    endcase
  end

  // ---------------- operand deserialiser ----------------
  // Each beat slot only loads on an accepted beat with its own index, so
  // in_valid outside COLLECT never touches the operands.
  for (genvar gi = 0; gi < NB; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_reg[gi*BUS_W +: BUS_W] <= '0;
        b_reg[gi*BUS_W +: BUS_W] <= '0;
      end else if (in_valid && in_ready && (beat_reg == CNT_W'(gi))) begin
        a_reg[gi*BUS_W +: BUS_W] <= a_in;
        b_reg[gi*BUS_W +: BUS_W] <= b_in;
      end
    end
  end

  log_afpm_datapath #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .calc1_en (calc1_en),
    .calc2_en (calc2_en),
    .a        (a_reg[W-1:0]),
    .b        (b_reg[W-1:0]),
    .result   (result),
    .flags    (flags_dp)
  );

  // ---------------- result serialiser ----------------
  logic [BUS_W-1:0] res_beats [NB];

  assign res_wide = (NB*BUS_W)'(result);

  for (genvar gi = 0; gi < NB; gi++) begin : g_beat
    assign res_beats[gi] = res_wide[gi*BUS_W +: BUS_W];
  end

  assign out_data = out_valid ? res_beats[beat_reg] : '0;
  assign flags    = out_valid ? flags_dp : 2'b00;

endmodule

// File: tb/tb_log_afpm_param.sv
// Directed testbench for log_afpm_param at default parameters (16-bit words,
// two 8-bit beats). Expected results depend on LOG_AFPM_CORR_EN where the
// correction changes the product.
module tb_log_afpm_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in, b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  log_afpm_param dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_in     = a[i*8 +: 8];
      b_in     = b[i*8 +: 8];
      check("in_ready_collect", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    a_in     = 8'h00;
    b_in     = 8'h00;
  endtask

  task automatic get_word(output logic [15:0] w, output logic [1:0] f, output int lat);
    lat = 0;
    w   = 16'h0000;
    f   = 2'b00;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    for (int j = 0; j < 2; j++) begin
      w[j*8 +: 8] = out_data;
      if (j == 0) f = flags;
      tick();
    end
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp_w, input logic [1:0] exp_f);
    logic [15:0] w;
    logic [1:0]  f;
    int          lat;
    put_word(a, b);
    get_word(w, f, lat);
    check({tag, "_latency"}, lat, 32'd2);
    check({tag, "_result"}, {16'd0, w}, {16'd0, exp_w});
    check({tag, "_flags"}, {30'd0, f}, {30'd0, exp_f});
    $display("txn %s A=%h B=%h result=%h flags=%b latency=%0d", tag, a, b, w, f, lat);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, "_out_data"},  {24'd0, out_data},  32'd0);
    check({tag, "_flags"},     {30'd0, flags},     32'd0);
  endtask

  logic [15:0] word;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = 8'h00;
    b_in      = 8'h00;
    out_ready = 1'b1;
    repeat (3) tick();
    check_idle("reset_held");
    rst = 1'b0;
    tick();
    check_idle("after_reset");

    // Main function
    run("mul_2x3", 16'h4000, 16'h4200, 16'h4600, 2'b00);
`ifdef LOG_AFPM_CORR_EN
    run("mul_1p5sq", 16'h3E00, 16'h3E00, 16'h4080, 2'b00);
`else
    run("mul_1p5sq", 16'h3E00, 16'h3E00, 16'h4000, 2'b00);
`endif
    run("mul_neg", 16'hC000, 16'h4200, 16'hC600, 2'b00);
    run("mul_zero", 16'h0000, 16'h4200, 16'h0000, 2'b00);
    run("ovf_exp", 16'h7800, 16'h7800, 16'h7BFF, 2'b10);
    run("unf_exp", 16'h0400, 16'h0400, 16'h0000, 2'b01);
    run("ovf_inf", 16'h7C00, 16'h3C00, 16'h7BFF, 2'b10);

    // Back-pressure on beat 0 and in_valid pulses outside COLLECT
    put_word(16'h3C00, 16'h4155);        // now in CALC1
    in_valid = 1'b1;
    a_in     = 8'hFF;
    b_in     = 8'hFF;
    tick();                              // CALC2
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();                              // SEND, stalled
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_data", {24'd0, out_data}, 32'h55);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    a_in      = 8'h00;
    b_in      = 8'h00;
    out_ready = 1'b1;
    word[7:0] = out_data;
    check("stall_flags", {30'd0, flags}, 32'd0);
    tick();
    word[15:8] = out_data;
    tick();
    check("stall_result", {16'd0, word}, 32'h4155);
    check("stall_back_to_collect", {31'd0, in_ready}, 32'd1);
    $display("txn stall A=3c00 B=4155 result=%h", word);

    // Reset in the middle of collecting
    in_valid = 1'b1;
    a_in     = 8'h00;
    b_in     = 8'h00;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    check_idle("mid_reset");
    rst = 1'b0;
    tick();
    run("after_mid_reset", 16'h4000, 16'h4200, 16'h4600, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
